// File: rtl/hamming_pkg.sv
// Shared SECDED (8,4) definitions: codeword bit positions, encoder and tx state encoding.
// Imported by both the transmit and the decode side of the link.
package hamming_pkg;

  localparam int unsigned P1_POS = 0;
  localparam int unsigned P2_POS = 1;
  localparam int unsigned D0_POS = 2;
  localparam int unsigned P4_POS = 3;
  localparam int unsigned D1_POS = 4;
  localparam int unsigned D2_POS = 5;
  localparam int unsigned D3_POS = 6;
  localparam int unsigned P0_POS = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  function automatic logic [7:0] hamming_encode(input logic [3:0] d);
    logic [7:0] cw;
    cw         = 8'h00;
    cw[P1_POS] = d[0] ^ d[1] ^ d[3];
    cw[P2_POS] = d[0] ^ d[2] ^ d[3];
    cw[D0_POS] = d[0];
    cw[P4_POS] = d[1] ^ d[2] ^ d[3];
    cw[D1_POS] = d[1];
    cw[D2_POS] = d[2];
    cw[D3_POS] = d[3];
    // Even overall parity across the seven Hamming bits.
    cw[P0_POS] = ^cw[6:0];
    return cw;
  endfunction

endpackage

// File: rtl/hamming_tx_baud_gen.sv
// Bit-period tick generator: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last count.
// Synchronous clear restarts the period so a frame's start bit is a full period long.
module hamming_tx_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last;

  assign last   = (cnt_q == CntMax);
  assign tick_o = en_i && last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hamming_tx_serial.sv
// SECDED (8,4) transmitter: encodes a 4-bit word and sends it as start, 8 code bits LSB first,
// then STOP_BITS stop periods. Optional HAMMING_TX_ERR_INJECT_EN adds err_mask XOR on accept.
module hamming_tx_serial
  import hamming_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in,
`ifdef HAMMING_TX_ERR_INJECT_EN
  input  logic [7:0] err_mask,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx_serial,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] codeword_out
);

  localparam logic StopLast = (STOP_BITS > 1) ? 1'b1 : 1'b0;

  tx_state_t  state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] cw_q, cw_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;

  logic       accept;
  logic       tick;
  logic [7:0] cw_new;

`ifdef HAMMING_TX_ERR_INJECT_EN
  assign cw_new = hamming_encode(data_in) ^ err_mask;
`else
  assign cw_new = hamming_encode(data_in);
`endif

  // ready_q is only set in IDLE, so no separate state qualifier is needed.
  assign accept = in_valid && ready_q;

  hamming_tx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept),
    .en_i  (busy_q),
    .tick_o(tick)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cw_d       = cw_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d    = START;
          shreg_d    = cw_new;
          cw_d       = cw_new;
          bit_idx_d  = 3'd0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
        end
      end

      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
      end

      DATA: begin
        if (tick) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
            tx_d       = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_q[1];
          end
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (stop_cnt_q == StopLast) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= 8'h00;
      cw_q       <= 8'h00;
      bit_idx_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cw_q       <= cw_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign tx_serial    = tx_q;
  assign busy         = busy_q;
  assign in_ready     = ready_q;
  assign frame_done   = done_q;
  assign codeword_out = cw_q;

endmodule

// File: tb/tb_hamming_tx_serial.sv
// Directed bench for hamming_tx_serial: instance a uses one stop bit, instance b uses two.
module tb_hamming_tx_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] data_in;
  logic       in_valid_a, in_valid_b;
  logic       in_ready_a, in_ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;
  logic [7:0] cw_a, cw_b;
`ifdef HAMMING_TX_ERR_INJECT_EN
  logic [7:0] err_mask;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hamming_tx_serial #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
`ifdef HAMMING_TX_ERR_INJECT_EN
    .err_mask    (err_mask),
`endif
    .in_valid    (in_valid_a),
    .in_ready    (in_ready_a),
    .tx_serial   (tx_a),
    .busy        (busy_a),
    .frame_done  (done_a),
    .codeword_out(cw_a)
  );

  hamming_tx_serial #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
`ifdef HAMMING_TX_ERR_INJECT_EN
    .err_mask    (err_mask),
`endif
    .in_valid    (in_valid_b),
    .in_ready    (in_ready_b),
    .tx_serial   (tx_b),
    .busy        (busy_b),
    .frame_done  (done_b),
    .codeword_out(cw_b)
  );

  // Line level at cycle c after acceptance: 4 start cycles, 8 bits x 4 cycles, then high.
  function automatic logic [63:0] exp_wave(input logic [7:0] cw);
    logic [63:0] w;
    for (int c = 0; c < 64; c++) begin
      if (c < 4) w[c] = 1'b0;
      else if (c < 36) w[c] = cw[(c - 4) / 4];
      else w[c] = 1'b1;
    end
    return w;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input bit sel, input logic [3:0] d);
    logic rdy;
    bit   ok;
    ok      = 1'b0;
    data_in = d;
    if (sel) in_valid_b = 1'b1;
    else in_valid_a = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rdy = sel ? in_ready_b : in_ready_a;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready never high, got 0 want 1");
    end
  endtask

  // Samples cycles 0..ncyc-1 of a frame; cycle 0 is the sample right after acceptance.
  task automatic capture(input bit sel, input int ncyc, output logic [63:0] wave,
                         output int done_at, output int done_cnt, output bit rdy_seen);
    wave     = '1;
    done_at  = -1;
    done_cnt = 0;
    rdy_seen = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      wave[c] = sel ? tx_b : tx_a;
      if (sel ? done_b : done_a) begin
        if (done_at < 0) done_at = c;
        done_cnt++;
      end
      if (c < ncyc - 1 && (sel ? in_ready_b : in_ready_a)) rdy_seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    data_in    = 4'h0;
`ifdef HAMMING_TX_ERR_INJECT_EN
    err_mask   = 8'h00;
`endif
    repeat (2) @(posedge clk);
    #1;
    tests++; if (tx_a !== 1'b1) begin fails++; $display("FAIL rst_tx: got %b want 1", tx_a); end
    tests++; if (in_ready_a !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", in_ready_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", done_a); end
    tests++; if (cw_a !== 8'h00) begin fails++; $display("FAIL rst_cw: got %h want 00", cw_a); end
    tests++; if (tx_b !== 1'b1 || cw_b !== 8'h00 || in_ready_b !== 1'b1) begin
      fails++; $display("FAIL rst_b: got tx=%b cw=%h rdy=%b want 1 00 1", tx_b, cw_b, in_ready_b);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (tx_a !== 1'b1 || busy_a !== 1'b0 || in_ready_a !== 1'b1) begin
      fails++; $display("FAIL idle_after_rst: got tx=%b busy=%b rdy=%b want 1 0 1", tx_a, busy_a,
                        in_ready_a);
    end
  endtask

  task automatic test_basic;
    logic [63:0] w;
    int          dat, dcnt;
    bit          rs;
    send(1'b0, 4'hB);
    tests++; if (cw_a !== 8'h55) begin fails++; $display("FAIL basic_cw: got %h want 55", cw_a); end
    tests++; if (busy_a !== 1'b1 || in_ready_a !== 1'b0) begin
      fails++; $display("FAIL basic_busy: got busy=%b rdy=%b want 1 0", busy_a, in_ready_a);
    end
    capture(1'b0, 41, w, dat, dcnt, rs);
    tests++; if (w !== exp_wave(8'h55)) begin fails++; $display("FAIL basic_wave: got %h want %h", w, exp_wave(8'h55)); end
    tests++; if (dat !== 40 || dcnt !== 1) begin
      fails++; $display("FAIL basic_done: got at=%0d n=%0d want at=40 n=1", dat, dcnt);
    end
    tests++; if (rs !== 1'b0 || in_ready_a !== 1'b1 || busy_a !== 1'b0) begin
      fails++; $display("FAIL basic_ready: got early=%b rdy=%b busy=%b want 0 1 0", rs, in_ready_a,
                        busy_a);
    end
    tests++; if (cw_a !== 8'h55) begin fails++; $display("FAIL basic_cw_hold: got %h want 55", cw_a); end
  endtask

  task automatic test_patterns;
    logic [3:0]  din [3] = '{4'h0, 4'hF, 4'h1};
    logic [7:0]  exp [3] = '{8'h00, 8'hFF, 8'h87};
    logic [63:0] w;
    int          dat, dcnt;
    bit          rs;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, din[i]);
      tests++; if (cw_a !== exp[i]) begin
        fails++; $display("FAIL pat_cw[%0d]: got %h want %h", i, cw_a, exp[i]);
      end
      capture(1'b0, 41, w, dat, dcnt, rs);
      tests++; if (w !== exp_wave(exp[i]) || dat !== 40) begin
        fails++; $display("FAIL pat_wave[%0d]: got %h at=%0d want %h at=40", i, w, dat,
                          exp_wave(exp[i]));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] w;
    int          dat, dcnt;
    bit          rs;
    bit          ok;
    logic        rdy;
    ok         = 1'b0;
    data_in    = 4'h1;
    in_valid_a = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rdy = in_ready_a;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    tests++; if (!ok) begin fails++; $display("FAIL b2b_accept1: got 0 want 1"); end
    data_in = 4'h2;  // in_valid stays high through the whole first frame
    capture(1'b0, 41, w, dat, dcnt, rs);
    tests++; if (w !== exp_wave(8'h87) || dat !== 40 || rs !== 1'b0) begin
      fails++; $display("FAIL b2b_frame1: got %h at=%0d early=%b want %h at=40 early=0", w, dat, rs,
                        exp_wave(8'h87));
    end
    tests++; if (cw_a !== 8'h87 || busy_a !== 1'b0) begin
      fails++; $display("FAIL b2b_gap: got cw=%h busy=%b want 87 0", cw_a, busy_a);
    end
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    tests++; if (cw_a !== 8'h99 || busy_a !== 1'b1 || tx_a !== 1'b0) begin
      fails++; $display("FAIL b2b_accept2: got cw=%h busy=%b tx=%b want 99 1 0", cw_a, busy_a, tx_a);
    end
    capture(1'b0, 41, w, dat, dcnt, rs);
    tests++; if (w !== exp_wave(8'h99) || dat !== 40) begin
      fails++; $display("FAIL b2b_frame2: got %h at=%0d want %h at=40", w, dat, exp_wave(8'h99));
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] w;
    int          dat, dcnt;
    bit          rs;
    send(1'b0, 4'hB);
    repeat (17) begin
      @(posedge clk);
      #1;
    end
    tests++; if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
      fails++; $display("FAIL mid_bit3: got tx=%b busy=%b want 0 1", tx_a, busy_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (tx_a !== 1'b1 || busy_a !== 1'b0 || in_ready_a !== 1'b1 || cw_a !== 8'h00) begin
      fails++; $display("FAIL mid_rst: got tx=%b busy=%b rdy=%b cw=%h want 1 0 1 00", tx_a, busy_a,
                        in_ready_a, cw_a);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 4'hB);
    capture(1'b0, 41, w, dat, dcnt, rs);
    tests++; if (cw_a !== 8'h55 || w !== exp_wave(8'h55) || dat !== 40) begin
      fails++; $display("FAIL mid_resend: got cw=%h %h at=%0d want 55 %h at=40", cw_a, w, dat,
                        exp_wave(8'h55));
    end
  endtask

  task automatic test_stop2;
    logic [63:0] w;
    int          dat, dcnt;
    bit          rs;
    send(1'b1, 4'hB);
    capture(1'b1, 45, w, dat, dcnt, rs);
    tests++; if (cw_b !== 8'h55 || w !== exp_wave(8'h55)) begin
      fails++; $display("FAIL stop2_wave: got cw=%h %h want 55 %h", cw_b, w, exp_wave(8'h55));
    end
    tests++; if (dat !== 44 || dcnt !== 1 || rs !== 1'b0) begin
      fails++; $display("FAIL stop2_done: got at=%0d n=%0d early=%b want at=44 n=1 early=0", dat, dcnt,
                        rs);
    end
  endtask

`ifdef HAMMING_TX_ERR_INJECT_EN
  task automatic test_err_inject;
    logic [63:0] w;
    int          dat, dcnt;
    bit          rs;
    err_mask = 8'h04;
    send(1'b0, 4'hB);
    err_mask = 8'h00;
    tests++; if (cw_a !== 8'h51) begin fails++; $display("FAIL inj_cw: got %h want 51", cw_a); end
    capture(1'b0, 41, w, dat, dcnt, rs);
    tests++; if (w !== exp_wave(8'h51)) begin
      fails++; $display("FAIL inj_wave: got %h want %h", w, exp_wave(8'h51));
    end
    send(1'b0, 4'hB);
    tests++; if (cw_a !== 8'h55) begin fails++; $display("FAIL inj_clean: got %h want 55", cw_a); end
    capture(1'b0, 41, w, dat, dcnt, rs);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_back_to_back();
    test_reset_mid();
    test_stop2();
`ifdef HAMMING_TX_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
